dca_matrix_store_packer: RTL
============================

Name: dca_matrix_store_packer

Overview:
- Store-side element packer for the DCA matrix LSU.
- Takes one row of MATRIX_NUM_COL full-width LSU elements per handshake and truncates each element to the instruction's element size.
- Packs the truncated elements contiguously into a memory row buffer and generates the byte write strobe plus a per-transaction last-row flag.
- Sits between the LSU datapath and the AXI write-data builder; output is decoupled by a 2-entry skid buffer.

Parameters:
- MATRIX_NUM_COL, 4, elements per row.
- BW_LSU_ELEMENT, 32, width of one LSU element.
- BW_TXN_INFO, 8, opaque transaction tag carried with each row.
- BW_NUM_ROW_M1, 8, width of the rows-minus-one field.
- BW_NUM_COL_M1, 3, width of the cols-minus-one field.
- BW_MEMORY_ROW_BUFFER, 32*MATRIX_NUM_COL, packed output row width.

Ports:
- clk  in  1  clock
- rstnn  in  1  reset, synchronous, active-low
- clear  in  1  synchronous flush; same effect as reset
- inst_size_code  in  3  element size code: 0=1b, 1=2b, 2=4b, 3=8b, 4=16b, 5=32b; codes 6 and 7 are treated as 32b
- inst_num_row_m1  in  BW_NUM_ROW_M1  rows in the transaction minus 1
- inst_num_col_m1  in  BW_NUM_COL_M1  valid columns minus 1
- in_valid  in  1  input row valid
- in_ready  out  1  input row accepted when in_valid && in_ready
- in_row  in  BW_LSU_ELEMENT*MATRIX_NUM_COL  element row; column i at [BW_LSU_ELEMENT*i +: BW_LSU_ELEMENT]
- in_txn_info  in  BW_TXN_INFO  tag for this row
- out_valid  out  1  packed row valid
- out_ready  in  1  downstream accept
- out_row  out  BW_MEMORY_ROW_BUFFER  packed row
- out_wstrb  out  BW_MEMORY_ROW_BUFFER/8  byte strobe
- out_last  out  1  final row of the transaction
- out_txn_info  out  BW_TXN_INFO  tag for the row on out_row

Behaviour:
- Reset (rstnn=0 at a clk edge) and clear=1 have the same effect:
  - buffer emptied, row counter = 0;
  - out_valid=0, in_ready=1, out_row/out_wstrb/out_last/out_txn_info = 0.
- A row in flight when reset or clear is applied is dropped; there is no partial output.
- inst_* fields are sampled on every accepted input row and must be held stable for the whole transaction.
- Packing is combinational on the input side; the result is written into the buffer on accept. Let W = element bits from size code.
  - For column i <= inst_num_col_m1: packed[W*i +: W] = in_row[BW_LSU_ELEMENT*i +: W]. This is a plain truncation; sign is not checked and there is no saturation.
  - Packed bits above (num_col_m1+1)*W are 0.
- Strobe: nbytes = ceil((num_col_m1+1)*W/8); wstrb[b] = (b < nbytes).
  - Sub-byte partial bytes are strobed whole, with the unused bits set to 0.
- Row counter:
  - Increments on each accept.
  - On the accept where counter == inst_num_row_m1, the entry is tagged last=1 and the counter wraps to 0.
- Skid buffer: 2-entry FIFO with count 0..2.
  - in_ready = (count != 2); this is a registered-state decode, with no combinational path from out_ready.
  - out_valid = (count != 0). The head entry drives out_row, out_wstrb, out_last and out_txn_info.
  - Latency from accept to out_valid is 1 cycle. Throughput is 1 row per cycle while out_ready is held high.
  - Push and pop in the same cycle: count is unchanged and order is preserved.
  - count=2: in_ready=0 and no push occurs.
  - count=0: out_ready is ignored.
- Output fields are held stable while out_valid && !out_ready.

Decomposition:
- Shared package dca_lsu_pkg holds:
  - size-code constants SIZE_1B..SIZE_32B;
  - function size_code_to_bits (codes >5 map to 32);
  - function bytes_for_bits.
- Sub-module dca_store_row_skid_buffer: generic 2-entry valid/ready FIFO, parameterised on payload width. The payload is {last, txn_info, wstrb, row}.

Test Plan:
- size=3 (8b), num_col_m1=3, in_row={32'h000000DD, 32'h000000CC, 32'h000000BB, 32'h000000AA} (col3..col0), out_ready=1 -> next cycle out_row[31:0]=32'hDDCCBBAA, upper bits 0, out_wstrb=16'h000F, out_last=1 (num_row_m1=0).
- size=0 (1b), num_col_m1=2, columns = 1, 0, 1 (col0..col2) -> out_row[2:0]=3'b101, bits [7:3]=0, out_wstrb=16'h0001.
- size=4 (16b), num_col_m1=1, in_row col0=32'hFFFF8001, col1=32'h12345678 -> out_row[31:0]=32'h56788001, out_wstrb=16'h000F; size=7 with col0=32'hCAFEF00D -> out_row[31:0]=32'hCAFEF00D, out_wstrb=16'h000F (num_col_m1=0).
- num_row_m1=2, out_ready=0, 4 rows offered -> in_ready falls after 2 accepts. Then raise out_ready -> rows drain in order with out_last pattern 0,0,1; the 4th row is then accepted and gets out_last=0 (counter wrapped).
- Steady stream with out_ready=1 and in_valid=1 for 8 cycles -> 8 outputs on consecutive cycles; count never exceeds 1.
- 2 rows buffered, counter=1, assert clear for one cycle -> out_valid=0 next cycle, in_ready=1. The next row is tagged with counter 0 (last=1 when num_row_m1=0). Repeat the sequence with rstnn=0 -> identical result.

Source files
------------

// File: rtl/dca_lsu_pkg.sv
// Purpose: shared element-size codes and size helpers for the DCA matrix LSU.
// Latency: n/a (constants and pure functions only).
// Backpressure: n/a.
package dca_lsu_pkg;

    localparam logic [2:0] SIZE_1B  = 3'd0;
    localparam logic [2:0] SIZE_2B  = 3'd1;
    localparam logic [2:0] SIZE_4B  = 3'd2;
    localparam logic [2:0] SIZE_8B  = 3'd3;
    localparam logic [2:0] SIZE_16B = 3'd4;
    localparam logic [2:0] SIZE_32B = 3'd5;

    // Element width in bits; the two unused codes fall back to full 32b.
    function automatic logic [5:0] size_code_to_bits(input logic [2:0] code);
        case (code)
            SIZE_1B:  return 6'd1;
            SIZE_2B:  return 6'd2;
            SIZE_4B:  return 6'd4;
            SIZE_8B:  return 6'd8;
            SIZE_16B: return 6'd16;
            SIZE_32B: return 6'd32;
            default:  return 6'd32;
        endcase
    endfunction

    // Bytes needed to hold a bit count; partial bytes round up.
    function automatic logic [8:0] bytes_for_bits(input logic [8:0] bits);
        return (bits + 9'd7) >> 3;
    endfunction

endpackage

// File: rtl/dca_matrix_store_packer_if.sv
// Purpose: instruction fields plus input/output row streams of the store packer.
// Ports: inst_* (sampled per row), in_valid/in_ready/in_row/in_txn_info,
//        out_valid/out_ready/out_row/out_wstrb/out_last/out_txn_info.
// Modports: master = LSU datapath + write-data builder side, slave = packer.
interface dca_matrix_store_packer_if #(
    parameter int MATRIX_NUM_COL       = 4,
    parameter int BW_LSU_ELEMENT       = 32,
    parameter int BW_TXN_INFO          = 8,
    parameter int BW_NUM_ROW_M1        = 8,
    parameter int BW_NUM_COL_M1        = 3,
    parameter int BW_MEMORY_ROW_BUFFER = 32 * MATRIX_NUM_COL
);
    logic [2:0]                               inst_size_code;
    logic [BW_NUM_ROW_M1-1:0]                 inst_num_row_m1;
    logic [BW_NUM_COL_M1-1:0]                 inst_num_col_m1;
    logic                                     in_valid;
    logic                                     in_ready;
    logic [BW_LSU_ELEMENT*MATRIX_NUM_COL-1:0] in_row;
    logic [BW_TXN_INFO-1:0]                   in_txn_info;
    logic                                     out_valid;
    logic                                     out_ready;
    logic [BW_MEMORY_ROW_BUFFER-1:0]          out_row;
    logic [BW_MEMORY_ROW_BUFFER/8-1:0]        out_wstrb;
    logic                                     out_last;
    logic [BW_TXN_INFO-1:0]                   out_txn_info;

    modport master (
        output inst_size_code, inst_num_row_m1, inst_num_col_m1,
        output in_valid, in_row, in_txn_info, out_ready,
        input  in_ready, out_valid, out_row, out_wstrb, out_last, out_txn_info
    );

    modport slave (
        input  inst_size_code, inst_num_row_m1, inst_num_col_m1,
        input  in_valid, in_row, in_txn_info, out_ready,
        output in_ready, out_valid, out_row, out_wstrb, out_last, out_txn_info
    );
endinterface

// File: rtl/dca_store_row_skid_buffer.sv
// Purpose: 2-entry valid/ready FIFO decoupling the packer from the write-data builder.
// Latency: 1 cycle from push to out_valid; sustains 1 entry/cycle with out_ready high.
// Backpressure: in_ready = not full, decoded from registered count only (no out_ready path).
// Ports: clk, rstnn (sync, active-low), clear (sync flush), in_valid/in_ready/in_data,
//        out_valid/out_ready/out_data (out_data is 0 while empty).
module dca_store_row_skid_buffer #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rstnn,
    input  logic             clear,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_data
);
    logic [WIDTH-1:0] mem [2];
    logic             wr_ptr;
    logic             rd_ptr;
    logic [1:0]       count;
    logic             push;
    logic             pop;

    assign in_ready  = (count != 2'd2);
    assign out_valid = (count != 2'd0);
    assign push      = in_valid && in_ready;
    assign pop       = out_valid && out_ready;
    // Gate the head so a flushed or empty buffer presents an all-zero payload.
    assign out_data  = out_valid ? mem[rd_ptr] : '0;

    always_ff @(posedge clk) begin
        if (!rstnn || clear) begin
            count  <= 2'd0;
            wr_ptr <= 1'b0;
            rd_ptr <= 1'b0;
        end else begin
            if (push) wr_ptr <= ~wr_ptr;
            if (pop)  rd_ptr <= ~rd_ptr;
            case ({push, pop})
                2'b10:   count <= count + 2'd1;
                2'b01:   count <= count - 2'd1;
                default: count <= count;
            endcase
        end
    end

    // Storage needs no reset: entries are only visible once count covers them.
    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr] <= in_data;
    end
endmodule

// File: rtl/dca_matrix_store_packer.sv
// Purpose: truncate each LSU element to the instruction element size, pack contiguously, build wstrb/last.
// Latency: 1 cycle from input accept to out_valid; 1 row/cycle while out_ready is high.
// Backpressure: in_ready drops only when the 2-entry output buffer is full (registered decode).
// Ports: clk, rstnn (sync, active-low), clear (sync flush, same effect as reset), bus (slave modport).
module dca_matrix_store_packer
    import dca_lsu_pkg::*;
#(
    parameter int MATRIX_NUM_COL       = 4,
    parameter int BW_LSU_ELEMENT       = 32,
    parameter int BW_TXN_INFO          = 8,
    parameter int BW_NUM_ROW_M1        = 8,
    parameter int BW_NUM_COL_M1        = 3,
    parameter int BW_MEMORY_ROW_BUFFER = 32 * MATRIX_NUM_COL
) (
    input logic                      clk,
    input logic                      rstnn,
    input logic                      clear,
    dca_matrix_store_packer_if.slave bus
);
    localparam int BW_WSTRB   = BW_MEMORY_ROW_BUFFER / 8;
    localparam int BW_PAYLOAD = 1 + BW_TXN_INFO + BW_WSTRB + BW_MEMORY_ROW_BUFFER;

    logic [5:0]                      elem_bits;
    logic [BW_NUM_COL_M1:0]          num_col;
    logic [8:0]                      used_bits;
    logic [8:0]                      used_bytes;
    logic [BW_LSU_ELEMENT-1:0]       elem_mask;
    logic [BW_MEMORY_ROW_BUFFER-1:0] packed_row;
    logic [BW_WSTRB-1:0]             wstrb;
    logic [BW_NUM_ROW_M1-1:0]        row_cnt;
    logic                            is_last;
    logic                            push;
    logic [BW_PAYLOAD-1:0]           in_payload;
    logic [BW_PAYLOAD-1:0]           out_payload;

    assign elem_bits  = size_code_to_bits(bus.inst_size_code);
    assign num_col    = {1'b0, bus.inst_num_col_m1} + 1'b1;
    assign used_bits  = 9'(elem_bits) * 9'(num_col);
    assign used_bytes = bytes_for_bits(used_bits);
    assign elem_mask  = (int'(elem_bits) >= BW_LSU_ELEMENT) ? {BW_LSU_ELEMENT{1'b1}}
                      : ({BW_LSU_ELEMENT{1'b1}} >> (BW_LSU_ELEMENT - int'(elem_bits)));

    // Column i lands at bit offset W*i; masking first keeps gaps and the tail zero.
    always_comb begin
        packed_row = '0;
        for (int i = 0; i < MATRIX_NUM_COL; i++) begin
            if (i < int'(num_col)) begin
                packed_row = packed_row
                    | (BW_MEMORY_ROW_BUFFER'(bus.in_row[BW_LSU_ELEMENT*i +: BW_LSU_ELEMENT] & elem_mask)
                       << (int'(elem_bits) * i));
            end
        end
    end

    // Strobe is a thermometer of the bytes touched; a partial last byte is strobed whole.
    always_comb begin
        wstrb = '0;
        for (int b = 0; b < BW_WSTRB; b++) begin
            wstrb[b] = (9'(b) < used_bytes);
        end
    end

    assign push    = bus.in_valid && bus.in_ready;
    assign is_last = (row_cnt == bus.inst_num_row_m1);

    always_ff @(posedge clk) begin
        if (!rstnn || clear) begin
            row_cnt <= '0;
        end else if (push) begin
            row_cnt <= is_last ? '0 : row_cnt + 1'b1;
        end
    end

    assign in_payload = {is_last, bus.in_txn_info, wstrb, packed_row};

    dca_store_row_skid_buffer #(
        .WIDTH (BW_PAYLOAD)
    ) u_skid (
        .clk       (clk),
        .rstnn     (rstnn),
        .clear     (clear),
        .in_valid  (bus.in_valid),
        .in_ready  (bus.in_ready),
        .in_data   (in_payload),
        .out_valid (bus.out_valid),
        .out_ready (bus.out_ready),
        .out_data  (out_payload)
    );

    assign {bus.out_last, bus.out_txn_info, bus.out_wstrb, bus.out_row} = out_payload;
endmodule
